// File: rtl/layer_train_sequencer.sv
// -----------------------------------------------------------------------------
// layer_train_sequencer
//
// Purpose:
//   This block sequences a neural layer through training or inference.
//   For each sample it does the following, in order:
//     1. fetch the sample from a source;
//     2. issue a forward pass and wait FWD_LAT cycles;
//     3. in train mode only, assert the learn strobe for LEARN_LAT cycles;
//     4. hand a result to a sink.
//   One epoch is SAMPLES samples. A run repeats the epoch num_epochs times,
//   and num_epochs = 0 counts as 1.
//
// Optional feature:
//   Define LAYER_SEQ_CYCLE_CNT_EN to add the 32-bit run_cycles output. It
//   clears at start, counts every busy cycle, saturates at all-ones and holds
//   after the run ends.
//
// Ports:
//   clock        : the single clock; all state changes on its rising edge
//   reset        : synchronous, active-high reset
//   start        : begins a run; sampled only in IDLE
//   train_mode   : 1 = forward + learn per sample, 0 = inference; captured at start
//   num_epochs   : epochs to run; captured at start
//   smp_valid    : sample source valid
//   smp_ready    : sample source ready (high only in FETCH)
//   layer_valid  : layer valid strobe
//   layer_learn  : layer learn strobe
//   res_valid    : result sink valid
//   res_ready    : result sink ready
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when a run completes
//   sample_idx   : index of the current sample within the epoch
//   epoch_idx    : index of the current epoch
//   run_cycles   : busy-cycle count (only with LAYER_SEQ_CYCLE_CNT_EN)
//
// All outputs come straight from flops. Each output flop loads a value
// decoded from the next state, so the outputs line up with the state
// register and never depend on an input within the same cycle.
// -----------------------------------------------------------------------------
module layer_train_sequencer #(
    parameter int FWD_LAT   = 2,
    parameter int LEARN_LAT = 1,
    parameter int SAMPLES   = 16,
    parameter int EPOCH_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               train_mode,
    input  logic [EPOCH_W-1:0] num_epochs,
    input  logic               smp_valid,
    output logic               smp_ready,
    output logic               layer_valid,
    output logic               layer_learn,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic               done,
    output logic [15:0]        sample_idx,
    output logic [EPOCH_W-1:0] epoch_idx
`ifdef LAYER_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]        run_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FWD,
        S_LEARN,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [3:0]  FWD_LAST    = 4'(FWD_LAT - 1);
    localparam logic [3:0]  LEARN_LAST  = 4'(LEARN_LAT - 1);
    localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLES - 1);

    state_t             state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [15:0]        sample_reg, sample_next;
    logic [EPOCH_W-1:0] epoch_reg, epoch_next;
    logic [EPOCH_W-1:0] epochs_reg, epochs_next;
    logic               mode_reg, mode_next;
    logic [EPOCH_W-1:0] epoch_last;

    logic smp_ready_reg, layer_valid_reg, layer_learn_reg, res_valid_reg;
    logic busy_reg, done_reg;
    logic smp_ready_next, layer_valid_next, layer_learn_next, res_valid_next;
    logic busy_next, done_next;

    // A captured epoch count of 0 behaves like 1, so the last epoch index is 0.
    assign epoch_last = (epochs_reg == '0) ? '0 : epochs_reg - EPOCH_W'(1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        sample_next = sample_reg;
        epoch_next  = epoch_reg;
        epochs_next = epochs_reg;
        mode_next   = mode_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mode_next   = train_mode;
                    epochs_next = num_epochs;
                    sample_next = '0;
                    epoch_next  = '0;
                    state_next  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (smp_valid && smp_ready_reg) begin
                    cnt_next   = '0;
                    state_next = S_FWD;
                end
            end
            S_FWD: begin
                if (cnt_reg == FWD_LAST) begin
                    cnt_next   = '0;
                    state_next = mode_reg ? S_LEARN : S_EMIT;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_LEARN: begin
                if (cnt_reg == LEARN_LAST) begin
                    cnt_next   = '0;
                    state_next = S_EMIT;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_EMIT: begin
                // res_valid_reg is high throughout EMIT, so res_ready alone
                // marks the transfer cycle.
                if (res_ready) begin
                    if (sample_reg != SAMPLE_LAST) begin
                        sample_next = sample_reg + 16'd1;
                        state_next  = S_FETCH;
                    end else begin
                        sample_next = '0;
                        if (epoch_reg == epoch_last) begin
                            state_next = S_DONE;
                        end else begin
                            epoch_next = epoch_reg + EPOCH_W'(1);
                            state_next = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Moore outputs decoded from the state about to be entered.
        // In FWD, layer_valid is high only on the entry cycle
        // (the counter is zero only there).
        smp_ready_next   = (state_next == S_FETCH);
        layer_valid_next = ((state_next == S_FWD) && (cnt_next == '0)) ||
                           (state_next == S_LEARN);
        layer_learn_next = (state_next == S_LEARN);
        res_valid_next   = (state_next == S_EMIT);
        busy_next        = (state_next != S_IDLE);
        done_next        = (state_next == S_DONE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            sample_reg      <= '0;
            epoch_reg       <= '0;
            epochs_reg      <= '0;
            mode_reg        <= 1'b0;
            smp_ready_reg   <= 1'b0;
            layer_valid_reg <= 1'b0;
            layer_learn_reg <= 1'b0;
            res_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            sample_reg      <= sample_next;
            epoch_reg       <= epoch_next;
            epochs_reg      <= epochs_next;
            mode_reg        <= mode_next;
            smp_ready_reg   <= smp_ready_next;
            layer_valid_reg <= layer_valid_next;
            layer_learn_reg <= layer_learn_next;
            res_valid_reg   <= res_valid_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
        end
    end

    assign smp_ready   = smp_ready_reg;
    assign layer_valid = layer_valid_reg;
    assign layer_learn = layer_learn_reg;
    assign res_valid   = res_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign sample_idx  = sample_reg;
    assign epoch_idx   = epoch_reg;

`ifdef LAYER_SEQ_CYCLE_CNT_EN
    logic [31:0] run_cycles_reg;

    // Counts the cycles in which busy is high. The count holds once the
    // sequencer returns to IDLE, and it saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_cycles_reg <= '0;
        end else if ((state_reg == S_IDLE) && start) begin
            run_cycles_reg <= '0;
        end else if (busy_reg && (run_cycles_reg != '1)) begin
            run_cycles_reg <= run_cycles_reg + 32'd1;
        end
    end

    assign run_cycles = run_cycles_reg;
`endif

endmodule

// File: tb/tb_layer_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_train_sequencer
//
// Scoreboard bench for layer_train_sequencer (FWD_LAT=2, LEARN_LAT=1,
// SAMPLES=3).
//
// At each start, the stimulus process pushes the expected (sample, epoch)
// sequence into a queue. That sequence comes from the run rules: for every
// epoch, every sample in order. A negedge monitor pops the queue on each
// result transfer and checks the following:
//   - the transfer's indices match the expected pair;
//   - exactly one forward issue happened for the sample;
//   - the number of learn cycles is right for the captured mode;
//   - the handshake and strobe rules hold on every cycle.
//
// Whole-run totals are checked at done: busy length, done pulse count and
// final indices.
// -----------------------------------------------------------------------------
module tb_layer_train_sequencer;

    localparam int FWD_LAT   = 2;
    localparam int LEARN_LAT = 1;
    localparam int SAMPLES   = 3;
    localparam int EPOCH_W   = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               train_mode = 1'b0;
    logic [EPOCH_W-1:0] num_epochs = '0;
    logic               smp_valid = 1'b0;
    logic               smp_ready;
    logic               layer_valid;
    logic               layer_learn;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               busy;
    logic               done;
    logic [15:0]        sample_idx;
    logic [EPOCH_W-1:0] epoch_idx;
`ifdef LAYER_SEQ_CYCLE_CNT_EN
    logic [31:0]        run_cycles;
`endif

    layer_train_sequencer #(
        .FWD_LAT  (FWD_LAT),
        .LEARN_LAT(LEARN_LAT),
        .SAMPLES  (SAMPLES),
        .EPOCH_W  (EPOCH_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .train_mode (train_mode),
        .num_epochs (num_epochs),
        .smp_valid  (smp_valid),
        .smp_ready  (smp_ready),
        .layer_valid(layer_valid),
        .layer_learn(layer_learn),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done),
        .sample_idx (sample_idx),
        .epoch_idx  (epoch_idx)
`ifdef LAYER_SEQ_CYCLE_CNT_EN
        ,
        .run_cycles (run_cycles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int s;
        int e;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Counters shared between the stimulus and the monitor.
    bit   cur_mode;
    int   fwd_issues;
    int   learn_cycles;
    int   done_pulses;
    int   busy_cycles;
    bit   prev_stalled;
    int   held_idx;

    // Stimulus controls.
    bit   tie_high;
    bit   stall_req;
    bit   stall_done;
    int   hold_cnt;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // -------------------------------------------------------------------------
    always @(negedge clock) begin
        if (!reset) begin
            if (busy) busy_cycles++;
            if (layer_valid && !layer_learn) fwd_issues++;
            if (layer_learn) learn_cycles++;
            if (layer_learn) check("learn_has_valid", layer_valid, 1);
            if (smp_ready) check("no_valid_in_fetch", layer_valid, 0);
            if (res_valid) check("no_valid_in_emit", layer_valid, 0);
            if (res_valid && prev_stalled) check("idx_held_in_stall", sample_idx, held_idx);
            if (res_valid && res_ready) begin
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("sample_idx", sample_idx, r.s);
                    check("epoch_idx", epoch_idx, r.e);
                    check("fwd_issues_per_sample", fwd_issues, 1);
                    check("learn_cycles_per_sample", learn_cycles, cur_mode ? LEARN_LAT : 0);
                    $display("result s=%0d e=%0d mode=%0d", sample_idx, epoch_idx, cur_mode);
                end
                fwd_issues   = 0;
                learn_cycles = 0;
            end
            if (done) begin
                done_pulses++;
                check("done_after_all_results", exp_q.size(), 0);
            end
            prev_stalled = res_valid && !res_ready;
            held_idx     = sample_idx;
        end else begin
            prev_stalled = 0;
        end
    end

    // One clock of stimulus: inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
        smp_valid = tie_high || ($urandom_range(99) >= 35);
        res_ready = tie_high || ($urandom_range(99) >= 35);
        if (hold_cnt > 0) begin
            res_ready = 1'b0;
            hold_cnt--;
        end else if (stall_req && !stall_done && res_valid) begin
            res_ready  = 1'b0;
            hold_cnt   = 4;
            stall_done = 1;
        end
    endtask

    task automatic clear_counters();
        fwd_issues   = 0;
        learn_cycles = 0;
        done_pulses  = 0;
        busy_cycles  = 0;
    endtask

    task automatic run(input bit mode, input int ne, input bit tie, input bit do_stall);
        int  eff;
        bit  got_done;
        tie_high   = tie;
        stall_req  = do_stall;
        stall_done = 0;
        hold_cnt   = 0;
        eff        = (ne == 0) ? 1 : ne;
        cur_mode   = mode;
        train_mode = mode;
        num_epochs = 8'(ne);
        for (int e = 0; e < eff; e++)
            for (int s = 0; s < SAMPLES; s++)
                exp_q.push_back('{s: s, e: e});
        clear_counters();
        start = 1'b1;
        step();
        start = 1'b0;
        got_done = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (done) begin
                got_done = 1;
                start    = 1'b0;
                break;
            end
            // Mid-run start and config changes must all be ignored.
            start      = ($urandom_range(7) == 0);
            train_mode = 1'($urandom_range(1));
            num_epochs = 8'($urandom_range(5));
        end
        start = 1'b0;
        check("run_done", got_done, 1);
        if (!got_done) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            exp_q.delete();
        end
        step();
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("done_pulses", done_pulses, 1);
        check("final_sample_idx", sample_idx, 0);
        check("final_epoch_idx", epoch_idx, eff - 1);
        check("queue_drained", exp_q.size(), 0);
        if (tie && !do_stall)
            check("busy_cycles", busy_cycles,
                  eff * SAMPLES * (2 + FWD_LAT + (mode ? LEARN_LAT : 0)) + 1);
`ifdef LAYER_SEQ_CYCLE_CNT_EN
        check("run_cycles", run_cycles, busy_cycles);
`endif
        $display("run mode=%0d epochs=%0d tie=%0d stall=%0d busy_cycles=%0d",
                 mode, ne, tie, do_stall, busy_cycles);
    endtask

    initial begin
        bit seen_learn;
        tie_high  = 1;
        stall_req = 0;
        hold_cnt  = 0;
        clear_counters();

        // Reset state.
        reset = 1'b1;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_smp_ready", smp_ready, 0);
        check("rst_layer_valid", layer_valid, 0);
        check("rst_layer_learn", layer_learn, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_sample_idx", sample_idx, 0);
        check("rst_epoch_idx", epoch_idx, 0);
        reset = 1'b0;
        step();

        // Directed runs with both handshakes tied high.
        run(1'b1, 1, 1'b1, 1'b0);   // train, one epoch
        run(1'b0, 1, 1'b1, 1'b0);   // inference only
        run(1'b1, 1, 1'b1, 1'b1);   // result sink stalls 5 cycles
        run(1'b1, 2, 1'b1, 1'b0);   // two epochs
        run(1'b0, 0, 1'b1, 1'b0);   // zero epochs behaves as one

        // Reset while the learn strobe is active.
        tie_high   = 1;
        cur_mode   = 1;
        train_mode = 1'b1;
        num_epochs = 8'd2;
        for (int s = 0; s < SAMPLES; s++) exp_q.push_back('{s: s, e: 0});
        clear_counters();
        start = 1'b1;
        step();
        start = 1'b0;
        seen_learn = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (layer_learn) begin
                seen_learn = 1;
                break;
            end
        end
        check("learn_reached", seen_learn, 1);
        reset = 1'b1;
        step();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_learn", layer_learn, 0);
        check("rst_mid_valid", layer_valid, 0);
        check("rst_mid_sample_idx", sample_idx, 0);
        check("rst_mid_epoch_idx", epoch_idx, 0);
        reset = 1'b0;
        exp_q.delete();
        clear_counters();
        step();
        run(1'b1, 1, 1'b1, 1'b0);

        // Randomized runs with random source and sink back-pressure.
        for (int r = 0; r < 8; r++)
            run(1'($urandom_range(1)), $urandom_range(3), 1'b0, 1'($urandom_range(1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
